// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg
// Shared types and constants for the FIR XIFU pipeline.
//   X_ID_WIDTH            : width of the X-interface instruction ID
//   NB_IDS                : number of distinct instruction IDs
//   fir_xifu_wb2regfile_t : WB -> XIFU regfile write port {write, rd, result}
//   fir_xifu_ex2wb_t      : EX -> WB payload held in the WB pipeline register
//   fir_xifu_commit_t     : X-interface commit channel payload
//   fir_xifu_result_t     : X-interface result channel payload
package fir_xifu_pkg;

    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned NB_IDS     = 2**X_ID_WIDTH;

    typedef logic [X_ID_WIDTH-1:0] x_id_t;

    typedef struct packed {
        logic        write;
        logic [4:0]  rd;
        logic [31:0] result;
    } fir_xifu_wb2regfile_t;

    typedef struct packed {
        x_id_t       id;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        write_xrf;
        logic        write_core;
    } fir_xifu_ex2wb_t;

    typedef struct packed {
        x_id_t id;
        logic  kill;
    } fir_xifu_commit_t;

    typedef struct packed {
        x_id_t       id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } fir_xifu_result_t;

endpackage

// File: rtl/fir_xifu_commit_table.sv
// fir_xifu_commit_table
// Per-ID commit/kill status recorded from the X-interface commit channel,
// with a combinational lookup that also sees the commit arriving this cycle.
//   clk_i, rst_ni         : clock, async active-low reset
//   commit_valid_i/id/kill: raw commit channel (sets status[id])
//   clr_i, clr_id_i       : clear status of a retiring or dropped instruction
//   lookup_id_i           : ID of the instruction currently in WB
//   committed_o, killed_o : effective status of lookup_id_i
module fir_xifu_commit_table
    import fir_xifu_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH,
    parameter int unsigned NB_IDS     = 2**X_ID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    input  logic                  clr_i,
    input  logic [X_ID_WIDTH-1:0] clr_id_i,
    input  logic [X_ID_WIDTH-1:0] lookup_id_i,
    output logic                  committed_o,
    output logic                  killed_o
);

    logic [NB_IDS-1:0] committed_q;
    logic [NB_IDS-1:0] killed_q;
    logic              fwd_hit;

    // A commit that hits the instruction retiring or dropping in the same
    // cycle was already consumed through the forward path, so the clear
    // wins and nothing is left behind in the table.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            committed_q <= '0;
            killed_q    <= '0;
        end else begin
            for (int i = 0; i < NB_IDS; i++) begin
                if (clr_i && (clr_id_i == X_ID_WIDTH'(i))) begin
                    committed_q[i] <= 1'b0;
                    killed_q[i]    <= 1'b0;
                end else if (commit_valid_i && (commit_id_i == X_ID_WIDTH'(i))) begin
                    committed_q[i] <= ~commit_kill_i;
                    killed_q[i]    <= commit_kill_i;
                end
            end
        end
    end

    assign fwd_hit     = commit_valid_i && (commit_id_i == lookup_id_i);
    assign committed_o = fwd_hit ? ~commit_kill_i : committed_q[lookup_id_i];
    assign killed_o    = fwd_hit ?  commit_kill_i : killed_q[lookup_id_i];

    // An ID is committed or killed at most once per instruction.
    a_no_double_commit : assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_valid_i |-> !(committed_q[commit_id_i] || killed_q[commit_id_i]));

    // A clear and a set on the same ID is only legal as the forwarded case.
    a_no_set_clr_clash : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (clr_i && commit_valid_i && (commit_id_i == clr_id_i))
            |-> !(committed_q[clr_id_i] || killed_q[clr_id_i]));

endmodule

// File: rtl/fir_xifu_wb.sv
// fir_xifu_wb
// Writeback stage of the FIR XIFU: holds one EX result until the core
// commits (result + regfile write) or kills (silent drop) it.
//   clk_i, rst_ni          : clock, async active-low reset
//   ex_*                   : EX handshake and payload
//   commit_*               : X-interface commit channel (always accepted)
//   result_*               : X-interface result channel
//   wb2regfile_o           : one-cycle XIFU regfile write {write, rd, result}
// The pipeline register uses fir_xifu_ex2wb_t, whose ID width comes from
// the package; X_ID_WIDTH must therefore match fir_xifu_pkg::X_ID_WIDTH.
module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH,
    parameter int unsigned NB_IDS     = 2**X_ID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [X_ID_WIDTH-1:0] ex_id_i,
    input  logic [4:0]            ex_rd_i,
    input  logic [31:0]           ex_result_i,
    input  logic                  ex_write_xrf_i,
    input  logic                  ex_write_core_i,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [31:0]           result_data_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o,
    output fir_xifu_wb2regfile_t  wb2regfile_o
);

    fir_xifu_ex2wb_t  wb_q;
    fir_xifu_commit_t commit;
    fir_xifu_result_t result;
    logic             valid_q;
    logic             eff_committed;
    logic             eff_killed;
    logic             result_valid;
    logic             retire;
    logic             drop;
    logic             load;

    assign commit = '{id: commit_id_i, kill: commit_kill_i};

    fir_xifu_commit_table #(
        .X_ID_WIDTH (X_ID_WIDTH),
        .NB_IDS     (NB_IDS)
    ) u_commit_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit.id),
        .commit_kill_i  (commit.kill),
        .clr_i          (retire | drop),
        .clr_id_i       (wb_q.id),
        .lookup_id_i    (wb_q.id),
        .committed_o    (eff_committed),
        .killed_o       (eff_killed)
    );

    assign drop         = valid_q & eff_killed;
    assign result_valid = valid_q & eff_committed & ~eff_killed;
    assign retire       = result_valid & result_ready_i;
    // Freeing the slot in the retire/drop cycle lets EX issue back-to-back.
    assign ex_ready_o   = ~valid_q | retire | drop;
    assign load         = ex_valid_i & ex_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            if (load) begin
                valid_q <= 1'b1;
                wb_q    <= '{id:         ex_id_i,
                             rd:         ex_rd_i,
                             result:     ex_result_i,
                             write_xrf:  ex_write_xrf_i,
                             write_core: ex_write_core_i};
            end else if (retire || drop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign result = '{id: wb_q.id, data: wb_q.result, rd: wb_q.rd, we: wb_q.write_core};

    assign result_valid_o = result_valid;
    assign result_id_o    = result.id;
    assign result_data_o  = result.data;
    assign result_rd_o    = result.rd;
    assign result_we_o    = result.we;

    assign wb2regfile_o = '{write:  retire & wb_q.write_xrf,
                            rd:     wb_q.rd,
                            result: wb_q.result};

    // IDs in flight are unique, so EX never presents the ID held here.
    a_no_id_alias : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ex_valid_i && valid_q) |-> (ex_id_i != wb_q.id));

    a_result_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (result_valid_o && !result_ready_i) |=> (result_valid_o && $stable(result)));

endmodule
